alu_arbiter_seq: RTL and testbench

ALU_ARBITER_SEQ -- requirements
Module: alu_arbiter_seq

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_core.sv | 74 +++++++
 rtl/alu_arbiter_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU sequencer.
//   - alu_op_e    : 4-bit opcode encoding
//   - alu_state_e : sequencer FSM states
//   - FLAG_*      : bit positions inside the {z,c,n,v} flag register
//   - MUL_ITER_DEF: default shift-add iteration count (operand width)
package alu_pkg;

    localparam int MUL_ITER_DEF = 8;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0010,
        OP_SUB    = 4'b0011,
        OP_SHL    = 4'b0100,
        OP_SHR    = 4'b0101,
        OP_AND    = 4'b0110,
        OP_OR     = 4'b0111,
        OP_XOR    = 4'b1000,
        OP_POPCNT = 4'b1001,
        OP_CMP    = 4'b1010,
        OP_MUL    = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU datapath with flag generation.
// Ports:
//   op        in  4  opcode (MUL is not handled here; it is sequenced
//                    by the top using this block's ADD path)
//   a, b      in  8  accumulator / register operand
//   flags_in  in  4  current {z,c,n,v}, passed through for illegal opcodes
//   data      out 8  result
//   flags_out out 4  new {z,c,n,v}
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] flags_in,
    output logic [7:0] data,
    output logic [3:0] flags_out
);

    logic [8:0] sum;
    logic [8:0] diff;
    logic [3:0] ones;
    logic       zn_from_data;

    always_comb begin
        sum          = {1'b0, a} + {1'b0, b};
        diff         = {1'b0, a} - {1'b0, b};
        ones         = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + 4'(b[i]);
        end
        data         = 8'h00;
        flags_out    = 4'h0;
        zn_from_data = 1'b1;

        case (op)
            OP_ADD: begin
                data              = sum[7:0];
                flags_out[FLAG_C] = sum[8];
                flags_out[FLAG_V] = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            OP_SUB: begin
                // diff[8] is the unsigned borrow
                data              = diff[7:0];
                flags_out[FLAG_C] = diff[8];
                flags_out[FLAG_V] = (a[7] != b[7]) && (diff[7] != a[7]);
            end
            OP_SHL:    data = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
            OP_SHR:    data = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
            OP_AND:    data = a & b;
            OP_OR:     data = a | b;
            OP_XOR:    data = a ^ b;
            OP_POPCNT: data = {4'h0, ones};
            OP_CMP: begin
                data              = a;
                zn_from_data      = 1'b0;
                flags_out[FLAG_Z] = (a == b);
                flags_out[FLAG_N] = diff[8];
            end
            default: begin
                // illegal: zero result, flag register left untouched
                data         = 8'h00;
                zn_from_data = 1'b0;
                flags_out    = flags_in;
            end
        endcase

        if (zn_from_data) begin
            flags_out[FLAG_Z] = (data == 8'h00);
            flags_out[FLAG_N] = data[7];
        end
    end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin front end to a small sequenced ALU.
// Single-cycle ops go through EXEC; MUL is a shift-add loop through the
// same core's ADD path. Result is held in RESP until consumed.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid[1:0]        per-requester request valid
//   req_ready[1:0]        per-requester accept (one-hot or zero)
//   req_op0/1, req_a0/1, req_b0/1   opcode and operands per requester
//   rsp_valid/rsp_ready   result handshake
//   rsp_id, rsp_data      owner and value of the result
//   flags                 {z,c,n,v} flag register
//   busy                  high whenever the FSM is not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request; the only state that grants
// ST_EXEC | one cycle: single-cycle result and flags are registered
// ST_MUL  | MUL_ITER cycles of shift-add; last one registers result
// ST_RESP | response held until rsp_ready
module alu_arbiter_seq
    import alu_pkg::*;
#(
    parameter int MUL_ITER = MUL_ITER_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_op0,
    input  logic [3:0] req_op1,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_b1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic [3:0] flags,
    output logic       busy
);

    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    alu_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       op_q, op_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       prod_q, prod_d;
    logic             ovf_q, ovf_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [3:0]       flags_q, flags_d;

    logic             grant;
    logic [1:0]       ready_vec;
    logic             accept;
    logic [3:0]       sel_op;
    logic [CNT_W-1:0] mul_idx;
    logic [15:0]      term16;
    logic             term_hi_nz;
    logic             mul_ovf;
    logic [3:0]       mul_flags;
    logic [3:0]       core_op;
    logic [7:0]       core_a;
    logic [7:0]       core_b;
    logic [7:0]       core_data;
    logic [3:0]       core_flags;

    always_comb begin
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
        ready_vec[0] = (state_q == ST_IDLE) && req_valid[0] && !grant;
        ready_vec[1] = (state_q == ST_IDLE) && req_valid[1] && grant;
    end

    assign accept    = |ready_vec;
    // state_q already reads IDLE during reset, so gate to keep ready low
    assign req_ready = ready_vec & {2{rst_n}};
    assign sel_op    = grant ? req_op1 : req_op0;

    // MUL bit index counts up while the iteration counter counts down
    assign mul_idx    = CNT_W'(MUL_ITER - 1) - cnt_q;
    assign term16     = {8'h00, a_q} << mul_idx;
    // a shifted term with bits above the byte already means product > 255
    assign term_hi_nz = b_q[mul_idx] && (term16[15:8] != 8'h00);

    always_comb begin
        if (state_q == ST_MUL) begin
            core_op = OP_ADD;
            core_a  = prod_q;
            core_b  = b_q[mul_idx] ? term16[7:0] : 8'h00;
        end else begin
            core_op = op_q;
            core_a  = a_q;
            core_b  = b_q;
        end
    end

    alu_core u_core (
        .op        (core_op),
        .a         (core_a),
        .b         (core_b),
        .flags_in  (flags_q),
        .data      (core_data),
        .flags_out (core_flags)
    );

    always_comb begin
        mul_ovf           = ovf_q | core_flags[FLAG_C] | term_hi_nz;
        mul_flags         = 4'h0;
        mul_flags[FLAG_Z] = (core_data == 8'h00);
        mul_flags[FLAG_C] = mul_ovf;
        mul_flags[FLAG_N] = core_data[7];
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        ovf_d       = ovf_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        flags_d     = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_d  = grant;
                    id_d    = grant;
                    op_d    = sel_op;
                    a_d     = grant ? req_a1 : req_a0;
                    b_d     = grant ? req_b1 : req_b0;
                    prod_d  = 8'h00;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(MUL_ITER - 1);
                    state_d = (sel_op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = core_data;
                flags_d     = core_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_MUL: begin
                prod_d = core_data;
                ovf_d  = mul_ovf;
                if (cnt_q == '0) begin
                    rsp_data_d  = core_data;
                    flags_d     = mul_flags;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            op_q        <= 4'h0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= 8'h00;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'h00;
            flags_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            flags_q     <= flags_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign flags     = flags_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq. Latency is counted in cycles after
// the cycle in which valid&ready was seen: EXEC ops respond after 2, MUL
// after 9. Inputs are driven and outputs sampled on the falling edge.
module tb_alu_arbiter_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_op0, req_op1;
    logic [7:0] req_a0, req_a1, req_b0, req_b1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic [3:0] flags;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter_seq #(.MUL_ITER(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .flags     (flags),
        .busy      (busy)
    );

    // Issue one request, wait for its response, consume it. Operands are
    // scrambled right after acceptance so only captured values can matter.
    task automatic do_op(input logic id, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] d, output logic [3:0] f,
                         output logic rid, output int lat);
        int t;
        d = 8'h00; f = 4'h0; rid = 1'b0; lat = -1;
        @(negedge clk);
        if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
        else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
        req_valid[id] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[id] && t < 50) begin @(negedge clk); #1; t++; end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: req%0d never got req_ready", id);
            req_valid[id] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_op0 = 4'hF; req_a0 = 8'hA5; req_b0 = 8'h5A;
        req_op1 = 4'hF; req_a1 = 8'h5A; req_b1 = 8'hA5;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_timeout: no rsp_valid for req%0d", id);
            return;
        end
        d = rsp_data; f = flags; rid = rsp_id;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req_op0 = 4'h2; req_op1 = 4'h2;
        req_a0 = 8'h00; req_a1 = 8'h00; req_b0 = 8'h00; req_b1 = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready_in_reset: got %b want 00", req_ready); end
        req_valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_arbitration();
        int t;
        @(negedge clk);
        req_op0 = 4'b0011; req_a0 = 8'd5;   req_b0 = 8'd7;
        req_op1 = 4'b1000; req_a1 = 8'hF0;  req_b1 = 8'h0F;
        req_valid = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL arb_first_grant: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        t = 1;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (rsp_data !== 8'hFE) begin n_err++; $display("FAIL arb_sub_data: got %h want fe", rsp_data); end
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL arb_sub_flags: got %b want 0110", flags); end
        n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL arb_sub_id: got %b want 0", rsp_id); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL arb_ready_in_resp: got %b want 00", req_ready); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL arb_second_grant: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        t = 1;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (rsp_data !== 8'hFF) begin n_err++; $display("FAIL arb_xor_data: got %h want ff", rsp_data); end
        n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL arb_xor_flags: got %b want 0010", flags); end
        n_cmp++; if (rsp_id !== 1'b1) begin n_err++; $display("FAIL arb_xor_id: got %b want 1", rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_add();
        logic [7:0] d; logic [3:0] f; logic rid; int lat;
        do_op(1'b0, 4'b0010, 8'd200, 8'd100, d, f, rid, lat);
        n_cmp++; if (d !== 8'd44) begin n_err++; $display("FAIL add_data: got %0d want 44", d); end
        n_cmp++; if (f !== 4'b0100) begin n_err++; $display("FAIL add_flags: got %b want 0100", f); end
        n_cmp++; if (rid !== 1'b0) begin n_err++; $display("FAIL add_id: got %b want 0", rid); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d want 2", lat); end
    endtask

    task automatic test_mul();
        logic [7:0] d; logic [3:0] f; logic rid; int lat;
        do_op(1'b1, 4'b1011, 8'd13, 8'd11, d, f, rid, lat);
        n_cmp++; if (d !== 8'd143) begin n_err++; $display("FAIL mul13x11_data: got %0d want 143", d); end
        n_cmp++; if (f !== 4'b0010) begin n_err++; $display("FAIL mul13x11_flags: got %b want 0010", f); end
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL mul_latency: got %0d want 9", lat); end
        do_op(1'b0, 4'b1011, 8'd20, 8'd20, d, f, rid, lat);
        n_cmp++; if (d !== 8'd144) begin n_err++; $display("FAIL mul20x20_data: got %0d want 144", d); end
        n_cmp++; if (f !== 4'b0110) begin n_err++; $display("FAIL mul20x20_flags: got %b want 0110", f); end
    endtask

    task automatic test_cmp_popcnt();
        logic [7:0] d; logic [3:0] f; logic rid; int lat;
        do_op(1'b0, 4'b1010, 8'd9, 8'd9, d, f, rid, lat);
        n_cmp++; if (d !== 8'd9) begin n_err++; $display("FAIL cmp_eq_data: got %0d want 9", d); end
        n_cmp++; if (f !== 4'b1000) begin n_err++; $display("FAIL cmp_eq_flags: got %b want 1000", f); end
        do_op(1'b1, 4'b1010, 8'd3, 8'd9, d, f, rid, lat);
        n_cmp++; if (d !== 8'd3) begin n_err++; $display("FAIL cmp_lt_data: got %0d want 3", d); end
        n_cmp++; if (f !== 4'b0010) begin n_err++; $display("FAIL cmp_lt_flags: got %b want 0010", f); end
        do_op(1'b0, 4'b1001, 8'h00, 8'hB5, d, f, rid, lat);
        n_cmp++; if (d !== 8'd5) begin n_err++; $display("FAIL popcnt_data: got %0d want 5", d); end
        n_cmp++; if (f !== 4'b0000) begin n_err++; $display("FAIL popcnt_flags: got %b want 0000", f); end
    endtask

    task automatic test_stall();
        int t;
        @(negedge clk);
        req_op1 = 4'b0010; req_a1 = 8'd1; req_b1 = 8'd2;
        req_valid = 2'b10;
        #1;
        t = 0;
        while (!req_ready[1] && t < 50) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        req_valid = 2'b01;
        req_op0 = 4'b0111; req_a0 = 8'h0C; req_b0 = 8'h30;
        req_a1 = 8'hEE;
        t = 1;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'd3 || rsp_id !== 1'b1 ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold cyc%0d: got v=%b d=%h id=%b rdy=%b busy=%b want v=1 d=03 id=1 rdy=00 busy=1",
                         i, rsp_valid, rsp_data, rsp_id, req_ready, busy);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 2'b01 || busy !== 1'b0) begin n_err++; $display("FAIL stall_release: got rdy=%b busy=%b want rdy=01 busy=0", req_ready, busy); end
        @(negedge clk);
        req_valid = 2'b00;
        t = 1;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (rsp_data !== 8'h3C || rsp_id !== 1'b0) begin n_err++; $display("FAIL stall_next_rsp: got d=%h id=%b want d=3c id=0", rsp_data, rsp_id); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_misc();
        logic [7:0] d; logic [3:0] f; logic rid; int lat;
        do_op(1'b0, 4'b0100, 8'h81, 8'd1, d, f, rid, lat);
        n_cmp++; if (d !== 8'h02 || f !== 4'b0000) begin n_err++; $display("FAIL shl: got d=%h f=%b want d=02 f=0000", d, f); end
        do_op(1'b0, 4'b0101, 8'h80, 8'd8, d, f, rid, lat);
        n_cmp++; if (d !== 8'h00 || f !== 4'b1000) begin n_err++; $display("FAIL shr_by8: got d=%h f=%b want d=00 f=1000", d, f); end
        do_op(1'b0, 4'b0011, 8'h80, 8'h01, d, f, rid, lat);
        n_cmp++; if (d !== 8'h7F || f !== 4'b0001) begin n_err++; $display("FAIL sub_ovf: got d=%h f=%b want d=7f f=0001", d, f); end
        do_op(1'b0, 4'b0010, 8'h7F, 8'h01, d, f, rid, lat);
        n_cmp++; if (d !== 8'h80 || f !== 4'b0011) begin n_err++; $display("FAIL add_ovf: got d=%h f=%b want d=80 f=0011", d, f); end
        do_op(1'b1, 4'b1111, 8'h12, 8'h34, d, f, rid, lat);
        n_cmp++; if (d !== 8'h00 || f !== 4'b0011 || rid !== 1'b1) begin n_err++; $display("FAIL illegal: got d=%h f=%b id=%b want d=00 f=0011 id=1", d, f, rid); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL illegal_latency: got %0d want 2", lat); end
    endtask

    task automatic test_reset_mul();
        int t;
        int seen;
        @(negedge clk);
        req_op0 = 4'b1011; req_a0 = 8'd20; req_b0 = 8'd20;
        req_valid = 2'b01;
        #1;
        t = 0;
        while (!req_ready[0] && t < 50) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        req_valid = 2'b10;
        req_op1 = 4'b0010;
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || flags !== 4'b0011 || rsp_id !== 1'b1) begin n_err++; $display("FAIL pre_reset_state: got busy=%b f=%b id=%b want busy=1 f=0011 id=1", busy, flags, rsp_id); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 ||
            rsp_data !== 8'h00 || flags !== 4'h0 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b v=%b id=%b d=%h f=%b rdy=%b want all zero",
                     busy, rsp_valid, rsp_id, rsp_data, flags, req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_add();
        test_mul();
        test_cmp_popcnt();
        test_stall();
        test_misc();
        test_reset_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
